fetch_ctrl: RTL

- Next-PC generator and fetch sequencer. It is the producer side of the PC register: it drives npc into PC and reads back pc.
- Decides each cycle whether PC increments, holds (stall or halt), or redirects (branch, jump, call, return).
- Tells decode whether the current fetch slot is valid, using a valid/ready handshake.
- Holds a small return-address stack (RAS) for call/ret.
- The PC register has no reset, so this block forces the reset vector into it.

---
 rtl/fetch_ctrl.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/fetch_ctrl.sv
// Next-PC generator and fetch sequencer: drives npc into the external PC register,
// gates the decode handshake, and keeps a circular return-address stack.
module fetch_ctrl #(
  parameter int              AW         = 16,
  parameter logic [AW-1:0]   RESET_VEC  = '0,
  parameter int              RAS_DEPTH  = 4,
  parameter int              BR_BUBBLES = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] pc,
  output logic [AW-1:0] npc,
  output logic          inst_valid,
  input  logic          inst_ready,
  input  logic          jmp,
  input  logic          call,
  input  logic          ret,
  input  logic [AW-1:0] jmp_target,
  input  logic          halt,
  input  logic          br_taken,
  input  logic [AW-1:0] br_target,
  output logic          halted,
  output logic          ras_err
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(BR_BUBBLES + 1);

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_FLUSH, S_HALT} state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] sp_q, sp_d;        // next free slot; top of stack is sp_q-1
  logic [CW-1:0] rcnt_q, rcnt_d;
  logic          err_q, err_d;
  logic          valid_q, halted_q;
  logic [AW-1:0] ras_q [RAS_DEPTH];

  logic          ras_we;
  logic [PW-1:0] ras_wa;
  logic [AW-1:0] ras_wd;
  logic          accept, ras_empty, ras_full;
  logic [PW-1:0] sp_top;
  logic [AW-1:0] pc_inc, ras_top;

  assign accept    = valid_q & inst_ready;
  assign pc_inc    = pc + AW'(1);
  assign sp_top    = sp_q - PW'(1);
  assign ras_top   = ras_q[sp_top];
  assign ras_empty = (rcnt_q == '0);
  assign ras_full  = (rcnt_q == CW'(RAS_DEPTH));

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    npc     = pc;
    state_d = state_q;
    cnt_d   = cnt_q;
    sp_d    = sp_q;
    rcnt_d  = rcnt_q;
    err_d   = err_q;
    ras_we  = 1'b0;
    ras_wa  = sp_q;
    ras_wd  = pc_inc;
    unique case (state_q)
      S_BOOT: begin
        npc     = RESET_VEC;
        state_d = S_RUN;
      end
      S_HALT: npc = pc;
      default: begin
        if (br_taken) begin
          npc     = br_target;
          cnt_d   = BW'(BR_BUBBLES);
          state_d = S_FLUSH;
        end else if (!accept) begin
          npc = pc;
          if (state_q == S_FLUSH) begin
            cnt_d = cnt_q - BW'(1);
            if (cnt_q <= BW'(1)) state_d = S_RUN;
          end
        end else if (halt) begin
          npc     = pc;
          state_d = S_HALT;
        end else if (ret || call || jmp) begin
          state_d = S_FLUSH;
          cnt_d   = BW'(1);
          if (ret && call && !ras_empty) begin
            // Tail call: return through the old top, which is replaced by our own return.
            npc    = ras_top;
            ras_we = 1'b1;
            ras_wa = sp_top;
          end else if (ret && !call) begin
            if (ras_empty) begin
              npc   = pc_inc;
              err_d = 1'b1;
            end else begin
              npc    = ras_top;
              sp_d   = sp_top;
              rcnt_d = rcnt_q - CW'(1);
            end
          end else if (call) begin
            npc    = jmp_target;
            ras_we = 1'b1;
            sp_d   = sp_q + PW'(1);
            if (!ras_full) rcnt_d = rcnt_q + CW'(1);
            if (ret) err_d = 1'b1;
          end else begin
            npc = jmp_target;
          end
        end else begin
          npc = pc_inc;
        end
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_BOOT;
      cnt_q    <= '0;
      sp_q     <= '0;
      rcnt_q   <= '0;
      err_q    <= 1'b0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sp_q     <= sp_d;
      rcnt_q   <= rcnt_d;
      err_q    <= err_d;
      valid_q  <= (state_d == S_RUN);
      halted_q <= (state_d == S_HALT);
    end
  end

  // NOTE: stack storage is deliberately not reset; rcnt_q alone says which entries are live.
  always_ff @(posedge clk) begin
    if (ras_we) ras_q[ras_wa] <= ras_wd;
  end

  assign inst_valid = valid_q;
  assign halted     = halted_q;
  assign ras_err    = err_q;

endmodule
